// File: rtl/aclk_keypad_scanner.sv
// 4x3 active-low matrix keypad scanner with column synchroniser, debounce and key encoding.
// Optional build macro AUTO_REPEAT_EN adds auto-repeat of held digit keys.
module aclk_keypad_scanner #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3,
  parameter int REPEAT_SCANS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key,
  output logic       alarm_button,
  output logic       time_button
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DEBOUNCE_CNT > 0) ? $clog2(DEBOUNCE_CNT + 1) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0] DEB_ONE    = CW'(1);
  localparam logic [3:0]    NOKEY      = 4'b1010;

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    EMIT         = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      col_meta_q, col_sync_q;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [1:0]      row_q, row_d;
  logic [3:0]      row_n_q, row_n_d;
  logic [1:0]      col_q, col_d;
  logic [CW-1:0]   deb_q, deb_d;
  logic [CW-1:0]   rel_q, rel_d;
  logic [3:0]      key_q, key_d;
  logic            alarm_q, alarm_d;
  logic            time_q, time_d;

  logic            sample;
  logic            one_low;
  logic            all_high;
  logic [1:0]      col_idx;
  logic            fire;

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS);
  logic [RW-1:0]   rep_q, rep_d;
`else
  localparam int unused_repeat_scans = REPEAT_SCANS;
`endif

  function automatic logic is_digit(input logic [1:0] r, input logic [1:0] c);
    return (r != 2'd3) || (c == 2'd1);
  endfunction

  // Bottom row only holds digit 0 in the middle column; the other rows count 1..9.
  function automatic logic [3:0] digit_code(input logic [1:0] r, input logic [1:0] c);
    if (r == 2'd3) begin
      return 4'd0;
    end
    return ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
  endfunction

  always_comb begin
    one_low = 1'b1;
    col_idx = 2'd0;
    case (col_sync_q)
      3'b110:  col_idx = 2'd0;
      3'b101:  col_idx = 2'd1;
      3'b011:  col_idx = 2'd2;
      default: one_low = 1'b0;
    endcase
  end

  assign all_high = &col_sync_q;
  assign sample   = (dwell_q == DWELL_LAST);

  always_comb begin
    state_d = state_q;
    dwell_d = sample ? '0 : dwell_q + DW'(1);
    row_d   = row_q;
    col_d   = col_q;
    deb_d   = deb_q;
    rel_d   = rel_q;
    fire    = 1'b0;
`ifdef AUTO_REPEAT_EN
    rep_d   = rep_q;
`endif

    case (state_q)
      SCAN: begin
        if (sample) begin
          if (one_low) begin
            col_d = col_idx;
            deb_d = DEB_ONE;
            if (DEB_ONE == DEB_LAST) begin
              fire    = 1'b1;
              state_d = EMIT;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            row_d = row_q + 2'd1;
          end
        end
      end

      DEBOUNCE: begin
        if (sample) begin
          if (one_low && (col_idx == col_q)) begin
            deb_d = deb_q + CW'(1);
            if ((deb_q + CW'(1)) == DEB_LAST) begin
              fire    = 1'b1;
              state_d = EMIT;
            end
          end else begin
            deb_d   = '0;
            row_d   = row_q + 2'd1;
            state_d = SCAN;
          end
        end
      end

      EMIT: begin
        deb_d   = '0;
        rel_d   = '0;
        state_d = WAIT_RELEASE;
`ifdef AUTO_REPEAT_EN
        rep_d   = '0;
`endif
      end

      WAIT_RELEASE: begin
        if (sample) begin
          if (all_high) begin
            if ((rel_q + CW'(1)) == DEB_LAST) begin
              rel_d   = '0;
              row_d   = row_q + 2'd1;
              state_d = SCAN;
            end else begin
              rel_d = rel_q + CW'(1);
            end
          end else begin
            rel_d = '0;
          end
`ifdef AUTO_REPEAT_EN
          // Only the originally latched digit, still alone, keeps the repeat timer running.
          if (one_low && (col_idx == col_q) && is_digit(row_q, col_q)) begin
            if ((rep_q + RW'(1)) == REP_LAST) begin
              rep_d = '0;
              fire  = 1'b1;
            end else begin
              rep_d = rep_q + RW'(1);
            end
          end else begin
            rep_d = '0;
          end
`endif
        end
      end

      default: begin
        state_d = SCAN;
      end
    endcase

    row_n_d = ~(4'b0001 << row_d);
  end

  // Outputs are registered so each pulse is high for exactly the EMIT (or repeat) cycle.
  always_comb begin
    key_d   = NOKEY;
    alarm_d = 1'b0;
    time_d  = 1'b0;
    if (fire) begin
      if (is_digit(row_q, col_idx)) begin
        key_d = digit_code(row_q, col_idx);
      end else if (col_idx == 2'd0) begin
        alarm_d = 1'b1;
      end else begin
        time_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta_q <= 3'b111;
      col_sync_q <= 3'b111;
      state_q    <= SCAN;
      dwell_q    <= '0;
      row_q      <= 2'd0;
      row_n_q    <= 4'b1110;
      col_q      <= 2'd0;
      deb_q      <= '0;
      rel_q      <= '0;
      key_q      <= NOKEY;
      alarm_q    <= 1'b0;
      time_q     <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_q      <= '0;
`endif
    end else begin
      col_meta_q <= col_n;
      col_sync_q <= col_meta_q;
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      row_q      <= row_d;
      row_n_q    <= row_n_d;
      col_q      <= col_d;
      deb_q      <= deb_d;
      rel_q      <= rel_d;
      key_q      <= key_d;
      alarm_q    <= alarm_d;
      time_q     <= time_d;
`ifdef AUTO_REPEAT_EN
      rep_q      <= rep_d;
`endif
    end
  end

  assign row_n        = row_n_q;
  assign key          = key_q;
  assign alarm_button = alarm_q;
  assign time_button  = time_q;

endmodule

// File: tb/tb_aclk_keypad_scanner.sv
// Scoreboard bench for aclk_keypad_scanner: a keypad model drives columns from row_n,
// expected emissions are queued at press time and a negedge monitor pops and compares.
module tb_aclk_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int REPEAT_SCANS = 16;
  localparam int LAT_MAX      = (4 + DEBOUNCE_CNT) * SCAN_DIV + 3;
  localparam logic [3:0] NOKEY = 4'b1010;
  localparam int STAR = 10;
  localparam int HASH = 11;
  localparam int KEY_LABEL [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{STAR, 0, HASH}};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;

  typedef struct {
    logic [3:0] key;
    logic       alarm;
    logic       tbtn;
    int         start;
  } exp_t;

  exp_t sb[$];
  bit   pressed [4][3];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_emit = 1'b0;

  aclk_keypad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .REPEAT_SCANS(REPEAT_SCANS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .col_n(col_n),
    .row_n(row_n),
    .key(key),
    .alarm_button(alarm_button),
    .time_button(time_button)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // A pressed switch connects its column to its row; rows are driven low one at a time.
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (pressed[r][c] && !row_n[r]) col_n[c] = 1'b0;
      end
    end
  end

  function automatic exp_t expect_for(input int r, input int c, input int start);
    exp_t e;
    int   label;
    label   = KEY_LABEL[r][c];
    e.key   = (label <= 9) ? 4'(label) : NOKEY;
    e.alarm = (label == STAR);
    e.tbtn  = (label == HASH);
    e.start = start;
    return e;
  endfunction

  always @(negedge clk) begin
    logic emit;
    exp_t e;
    emit = (key != NOKEY) || alarm_button || time_button;
    if (emit) begin
      checks++;
      if (prev_emit) begin
        errors++;
        $display("[TB] FAIL pulse_gap: got emission on two consecutive cycles (key=%b), want idle cycle between", key);
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_emit: got key=%b alarm=%b time=%b, want no emission", key, alarm_button, time_button);
      end else begin
        e = sb.pop_front();
        checks++;
        if (key !== e.key || alarm_button !== e.alarm || time_button !== e.tbtn) begin
          errors++;
          $display("[TB] FAIL emit_value: got key=%b alarm=%b time=%b, want key=%b alarm=%b time=%b",
                   key, alarm_button, time_button, e.key, e.alarm, e.tbtn);
        end
        if (e.start >= 0) begin
          checks++;
          if (cyc - e.start > LAT_MAX) begin
            errors++;
            $display("[TB] FAIL latency: got %0d cycles, want <= %0d", cyc - e.start, LAT_MAX);
          end
        end
      end
    end
    prev_emit = emit;
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++) pressed[r][c] = 1'b0;
  endtask

  task automatic apply_stimulus(input int r, input int c, input int hold, input int gap);
    @(negedge clk);
    pressed[r][c] = 1'b1;
    sb.push_back(expect_for(r, c, cyc));
    repeat (hold) @(negedge clk);
    release_all();
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s: got %0d emissions still pending, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("[TB] FAIL watchdog: got time limit reached, want finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [3:0] want_row;
    int n;
    release_all();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // Asynchronous reset in the middle of a scan.
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_output("reset_row_n", 32'(row_n), 32'(4'b1110));
    check_output("reset_key", 32'(key), 32'(NOKEY));
    check_output("reset_alarm", 32'(alarm_button), 32'd0);
    check_output("reset_time", 32'(time_button), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      want_row = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      check_output($sformatf("row_seq_%0d", k), 32'(row_n), 32'(want_row));
      @(negedge clk);
    end

    $display("[TB] digit 5, star and hash presses");
    apply_stimulus(1, 1, 200, 40);
    wait_drain("drain_digit5", 100);
    apply_stimulus(3, 0, 60, 40);
    wait_drain("drain_star", 100);
    apply_stimulus(3, 2, 60, 40);
    wait_drain("drain_hash", 100);

    $display("[TB] bounce on 7 and ghost on row 1");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pressed[2][0] = 1'b1;
      repeat (6) @(negedge clk);
      pressed[2][0] = 1'b0;
      repeat (5) @(negedge clk);
    end
    repeat (60) @(negedge clk);
    pressed[1][0] = 1'b1;
    pressed[1][2] = 1'b1;
    repeat (100) @(negedge clk);
    release_all();
    repeat (40) @(negedge clk);
    wait_drain("drain_reject", 10);

    $display("[TB] reset during debounce of 9");
    n = 0;
    while (row_n != 4'b1011 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_output("row2_reached", 32'(row_n), 32'(4'b1011));
    pressed[2][2] = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_output("key_during_reset", 32'(key), 32'(NOKEY));
    rst = 1'b1;
    sb.push_back(expect_for(2, 2, cyc));
    repeat (80) @(negedge clk);
    release_all();
    repeat (40) @(negedge clk);
    wait_drain("drain_reset_9", 100);

    $display("[TB] long hold of 3");
    @(negedge clk);
    pressed[0][2] = 1'b1;
    sb.push_back(expect_for(0, 2, cyc));
    wait_drain("first_emit_3", LAT_MAX + 5);
`ifdef AUTO_REPEAT_EN
    for (int i = 0; i < 5; i++) sb.push_back(expect_for(0, 2, -1));
`endif
    repeat (5 * REPEAT_SCANS * SCAN_DIV + 32) @(negedge clk);
    release_all();
    repeat (40) @(negedge clk);
    wait_drain("drain_hold_3", 100);

    $display("[TB] randomized presses");
    for (int i = 0; i < 12; i++) begin
      apply_stimulus($urandom_range(0, 3), $urandom_range(0, 2),
                     $urandom_range(40, 55), $urandom_range(30, 60));
      wait_drain($sformatf("drain_rand_%0d", i), 100);
    end

    repeat (20) @(negedge clk);
    wait_drain("drain_final", 10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aclk_keypad_scanner.md
Name: aclk_keypad_scanner

Overview:
Front-end that produces the key, alarm_button and time_button inputs consumed by the alarm-clock controller. It scans a 4x3 active-low matrix keypad, synchronises and debounces the columns, and encodes each debounced press.
- Digit keys emit a one-cycle 4-bit key code.
- '*' and '#' emit one-cycle alarm_button and time_button pulses.
- Idle key code is 4'b1010 (NOKEY).

Parameters:
SCAN_DIV, 4, clk cycles per row dwell; columns are sampled on the last cycle of each dwell; legal values are 2 or more.
DEBOUNCE_CNT, 3, consecutive identical samples required to accept a press and to accept a release; legal values are 1 or more.
REPEAT_SCANS, 16, samples between auto-repeat emissions; used only with AUTO_REPEAT_EN.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
col_n  in  3  keypad columns, active-low, pulled up externally, asynchronous.
row_n  out  4  row drive, one-hot-low.
key  out  4  key code; 4'b1010 when idle; digit 0-9 for exactly one cycle per press.
alarm_button  out  1  one-cycle pulse for '*'.
time_button  out  1  one-cycle pulse for '#'.

Behaviour:
- Reset values (rst=0, asynchronous): row_n=4'b1110, key=4'b1010, alarm_button=0, time_button=0, FSM=SCAN, all counters 0, synchroniser flops 3'b111.
- Column synchronisation: col_n passes through a 2-flop synchroniser; every decision uses the synchronised value.
- Dwell counter: counts 0 to SCAN_DIV-1 and runs in all states. The sample point is count==SCAN_DIV-1.
- Key map (row, column):
  - Row 0: columns 0/1/2 = 1, 2, 3.
  - Row 1: 4, 5, 6.
  - Row 2: 7, 8, 9.
  - Row 3: '*', 0, '#'.
- SCAN state:
  - At each sample point, exactly one column low: latch (row, col), debounce count=1, go to DEBOUNCE, row held.
  - No column low, or two or more low (ghost/invalid): advance row, wrapping 3->0.
- DEBOUNCE state:
  - At each sample point, the same single column low: count++.
  - Count reaches DEBOUNCE_CNT: go to EMIT.
  - Any other column pattern: return to SCAN and advance row.
  - With DEBOUNCE_CNT=1, the transition goes SCAN -> EMIT directly.
- EMIT state: one cycle.
  - Registered outputs are driven for exactly that cycle: key=code for a digit, alarm_button=1 for '*', time_button=1 for '#'.
  - key stays 4'b1010 for '*' and '#'.
  - Next state is WAIT_RELEASE.
- WAIT_RELEASE state:
  - Row held.
  - At each sample point, all columns high: release count++. Any column low: release count=0.
  - Release count reaches DEBOUNCE_CNT: go to SCAN and advance row.
- Single emission: exactly one emission per accepted press. A held key never emits twice (no macro).
- Pulse timing: outputs are 1-cycle, never back-to-back. Between emissions they are idle for at least 2*DEBOUNCE_CNT*SCAN_DIV cycles.
- Reset mid-operation: immediate return to reset values. A key still held after reset release is re-detected and emitted once.
- Latency: from a stable press to the output pulse, at most (4 + DEBOUNCE_CNT) * SCAN_DIV + 3 cycles.

Optional Feature:
AUTO_REPEAT_EN
- Defined: in WAIT_RELEASE, a repeat counter advances at each sample point while the latched column stays the only column low. Each time it reaches REPEAT_SCANS it re-emits that digit for one cycle, then clears. '*' and '#' never repeat. Any release sample clears the repeat counter.
- Undefined: no repeat logic; single emission per press.

Test Plan:
- Reset check: assert rst=0 mid-scan -> row_n=1110, key=1010, both buttons 0 asynchronously. After release, row_n cycles 1110,1101,1011,0111 every 4 clks.
- Digit press: keypad model pulls col1 low while row1 is driven, held 200 clks -> key=0101 for exactly 1 cycle, within 31 clks of press start; buttons stay 0; release -> scanning resumes.
- Button keys: press '*' (row3, col0) -> alarm_button 1-cycle pulse, key stays 1010. Press '#' (row3, col2) -> time_button 1-cycle pulse.
- Bounce and ghost rejection:
  - '7' toggled every 6 clks for 60 clks, then released -> no emission.
  - col0 and col2 low together -> no emission.
- Reset mid-debounce: press '9', assert rst after the first qualifying sample, keep key held -> no output during reset; exactly one key=1001 after reset release.
- Long hold of '3' for 400 clks:
  - Without AUTO_REPEAT_EN -> one key=0011 pulse.
  - With the macro (REPEAT_SCANS=16, SCAN_DIV=4) -> repeats every 64 clks after the first.
